serial_state_reg: RTL and testbench
===================================

Name: serial_state_reg

Overview:
Parametrised bit-serial state register for the serial cipher datapath. It holds DEPTH lanes of W bits in one shift chain. It presents the leading lane to an external S-box and applies the substitution on lane boundaries while the chain rotates. An internal sequencer handles load, processing passes and unload, so the datapath controller only issues start and reads the serial result.

Parameters:
W, 8, lane width in bits (S-box width), >=2
DEPTH, 16, number of lanes in the chain, >=1
PASSES, 1, number of full rotations per operation, >=1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin operation; accepted only while idle
sub_en  in  1  substitution enable; sampled on accepted start, held for the whole operation
abort  in  1  synchronous return to IDLE; chain cleared
din  in  1  serial load data, MSB of lane 0 first
din_req  out  1  high in LOAD; din is consumed on every such cycle
sbox_in  out  W  top W bits of chain (current leading lane)
sbox_out  in  W  external combinational S-box result for sbox_in
dout  out  1  serial result, MSB of lane 0 first
dout_valid  out  1  high in UNLOAD
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on the last UNLOAD cycle

Behaviour:
- Chain: N = DEPTH*W bits. MSB is the head; shift direction is towards the MSB.
- Counters: bit_cnt 0..W-1, lane_cnt 0..DEPTH-1, pass_cnt 0..PASSES-1. All wrap and clear on every state change.
- FSM states: IDLE, LOAD, PROC, UNLOAD.
  - IDLE -> LOAD when start=1. Latch sub_en in the same cycle.
  - LOAD -> PROC after N cycles.
  - PROC -> UNLOAD after PASSES*N cycles.
  - UNLOAD -> IDLE after N cycles.
- LOAD: chain <= {chain[N-2:0], din}.
- PROC with a plain rotate cycle: head = chain[N-1]; chain <= {chain[N-2:0], head}.
- PROC with a substitution cycle (bit_cnt==0 and sub_en latched):
  - head = sbox_out[W-1];
  - chain <= {sbox_out[W-2:0], chain[N-W-1:0], head}.
  - Result: every lane is substituted exactly once per pass, and lane order is restored at the end of each pass.
- UNLOAD: dout = chain[N-1]; chain <= {chain[N-2:0], 1'b0}. The chain is zero afterwards.
- dout outside UNLOAD: 0.
- sbox_in = chain[N-1:N-W] at all times. It is combinational, with no added latency; sbox_out must settle in the same cycle.
- Latency: start accepted at cycle T.
  - din_req is high for cycles T+1..T+N.
  - PROC runs T+N+1..T+N+PASSES*N.
  - dout_valid is high for the next N cycles, with done on the last of them.
  - Total: (2+PASSES)*N cycles.
- start while busy: ignored, with no queuing. start and abort together in IDLE: abort wins and the block stays IDLE.
- abort in any state: next cycle IDLE, chain and counters zero, no done pulse.
- rst_n low, including mid-operation: immediately IDLE, chain zero, counters zero, latched sub_en=0. Outputs on reset: din_req=0, dout=0, dout_valid=0, busy=0, done=0, sbox_in=0.
- DEPTH=1: every PROC cycle with bit_cnt==0 substitutes the single lane, and the rules above apply unchanged.

Decomposition:
- Shared package: FSM state enum (IDLE/LOAD/PROC/UNLOAD) and clog2-derived counter width functions for W, DEPTH and PASSES.
- One sub-module, serial_state_seq: the FSM plus the three counters. It outputs the phase strobes and a sub_cycle flag.
- The chain datapath stays in the top level.

Test Plan:
- W=8, DEPTH=2, PASSES=1, sub_en=1, sbox_out=~sbox_in; load 0xA5,0x3C -> dout 0x5A then 0xC3 MSB first; done at cycle T+48.
- Same load, sub_en=0 -> dout 0xA5,0x3C unchanged; sbox_in value ignored.
- PASSES=2, sbox_out=sbox_in+1 mod 256; load 0x00,0xFF -> dout 0x02,0x01.
- start pulsed during LOAD and during PROC -> ignored; exactly one done pulse, output as in the first scenario.
- abort in the 5th PROC cycle -> busy=0 next cycle, no done; a fresh start afterwards produces the correct result.
- rst_n asserted in mid-UNLOAD -> dout_valid=0, busy=0 and sbox_in=0 immediately; done never pulses.

Source files
------------

// File: rtl/serial_state_reg_pkg.sv
// Shared types and helpers for the bit-serial state register.
// Holds the phase encoding and the counter width helper used by the sequencer.
package serial_state_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_PROC   = 2'd2,
        ST_UNLOAD = 2'd3
    } state_e;

    // Counter width for a modulus n; a modulus of one still needs a 1-bit register.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_state_seq.sv
// Sequencer for serial_state_reg: phase FSM plus bit/lane/pass counters.
// Emits one-hot phase strobes and the lane-boundary substitution flag.
module serial_state_seq
    import serial_state_reg_pkg::*;
#(
    parameter int W      = 8,
    parameter int DEPTH  = 16,
    parameter int PASSES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic sub_en,
    input  logic abort,
    output logic load_en,
    output logic proc_en,
    output logic unload_en,
    output logic sub_cycle,
    output logic busy,
    output logic done
);

    localparam int BW = cnt_width(W);
    localparam int LW = cnt_width(DEPTH);
    localparam int PW = cnt_width(PASSES);
    localparam logic [BW-1:0] BIT_LAST  = BW'(W - 1);
    localparam logic [LW-1:0] LANE_LAST = LW'(DEPTH - 1);
    localparam logic [PW-1:0] PASS_LAST = PW'(PASSES - 1);

    state_e          state_r;
    state_e          state_s;
    logic [BW-1:0]   bit_cnt_r;
    logic [LW-1:0]   lane_cnt_r;
    logic [PW-1:0]   pass_cnt_r;
    logic            sub_en_r;
    logic            lane_end_s;
    logic            chain_end_s;
    logic            pass_end_s;

    // Wrap points of the nested counters.
    always_comb begin
        lane_end_s  = (bit_cnt_r == BIT_LAST);
        chain_end_s = lane_end_s && (lane_cnt_r == LANE_LAST);
        pass_end_s  = chain_end_s && (pass_cnt_r == PASS_LAST);
    end

    // Next-state logic; abort overrides everything, including a start in IDLE.
    always_comb begin
        state_s = state_r;
        if (abort) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:   if (start)       state_s = ST_LOAD;   else state_s = ST_IDLE;
                ST_LOAD:   if (chain_end_s) state_s = ST_PROC;   else state_s = ST_LOAD;
                ST_PROC:   if (pass_end_s)  state_s = ST_UNLOAD; else state_s = ST_PROC;
                ST_UNLOAD: if (chain_end_s) state_s = ST_IDLE;   else state_s = ST_UNLOAD;
                default:                    state_s = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Nested counters; all clear whenever the phase changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r  <= {BW{1'b0}};
            lane_cnt_r <= {LW{1'b0}};
            pass_cnt_r <= {PW{1'b0}};
        end else if (abort || (state_s != state_r) || (state_r == ST_IDLE)) begin
            bit_cnt_r  <= {BW{1'b0}};
            lane_cnt_r <= {LW{1'b0}};
            pass_cnt_r <= {PW{1'b0}};
        end else begin
            bit_cnt_r <= lane_end_s ? {BW{1'b0}} : bit_cnt_r + BW'(1);
            if (lane_end_s) begin
                lane_cnt_r <= (lane_cnt_r == LANE_LAST) ? {LW{1'b0}} : lane_cnt_r + LW'(1);
            end else begin
                lane_cnt_r <= lane_cnt_r;
            end
            if (chain_end_s) begin
                pass_cnt_r <= (pass_cnt_r == PASS_LAST) ? {PW{1'b0}} : pass_cnt_r + PW'(1);
            end else begin
                pass_cnt_r <= pass_cnt_r;
            end
        end
    end

    // Substitution enable is captured only when a start is actually accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_en_r <= 1'b0;
        end else if (abort) begin
            sub_en_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && start) begin
            sub_en_r <= sub_en;
        end else begin
            sub_en_r <= sub_en_r;
        end
    end

    // Phase strobes decoded from state and counters.
    always_comb begin
        load_en   = (state_r == ST_LOAD);
        proc_en   = (state_r == ST_PROC);
        unload_en = (state_r == ST_UNLOAD);
        busy      = (state_r != ST_IDLE);
        sub_cycle = proc_en && sub_en_r && (bit_cnt_r == {BW{1'b0}});
        done      = unload_en && chain_end_s && !abort;
    end

endmodule

// File: rtl/serial_state_reg.sv
// Bit-serial state register: DEPTH lanes of W bits in one shift chain, with the
// leading lane exposed to an external S-box and substituted on lane boundaries.
module serial_state_reg
    import serial_state_reg_pkg::*;
#(
    parameter int W      = 8,
    parameter int DEPTH  = 16,
    parameter int PASSES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub_en,
    input  logic         abort,
    input  logic         din,
    output logic         din_req,
    output logic [W-1:0] sbox_in,
    input  logic [W-1:0] sbox_out,
    output logic         dout,
    output logic         dout_valid,
    output logic         busy,
    output logic         done
);

    localparam int N = DEPTH * W;

    logic [N-1:0] chain_r;
    logic [N-1:0] chain_s;
    logic [N-1:0] sub_chain_s;
    logic         load_en_s;
    logic         proc_en_s;
    logic         unload_en_s;
    logic         sub_cycle_s;

    serial_state_seq #(
        .W      (W),
        .DEPTH  (DEPTH),
        .PASSES (PASSES)
    ) u_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub_en    (sub_en),
        .abort     (abort),
        .load_en   (load_en_s),
        .proc_en   (proc_en_s),
        .unload_en (unload_en_s),
        .sub_cycle (sub_cycle_s),
        .busy      (busy),
        .done      (done)
    );

    // Chain with the leading lane replaced by the S-box result (valid for any DEPTH).
    always_comb begin
        sub_chain_s            = chain_r;
        sub_chain_s[N-1 -: W]  = sbox_out;
    end

    // Next chain value: every active phase shifts one bit towards the head.
    always_comb begin
        chain_s = chain_r;
        if (load_en_s) begin
            chain_s = {chain_r[N-2:0], din};
        end else if (sub_cycle_s) begin
            chain_s = {sub_chain_s[N-2:0], sub_chain_s[N-1]};
        end else if (proc_en_s) begin
            chain_s = {chain_r[N-2:0], chain_r[N-1]};
        end else if (unload_en_s) begin
            chain_s = {chain_r[N-2:0], 1'b0};
        end else begin
            chain_s = chain_r;
        end
    end

    // Chain register; abort wipes the state so nothing leaks into the next operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_r <= {N{1'b0}};
        end else if (abort) begin
            chain_r <= {N{1'b0}};
        end else begin
            chain_r <= chain_s;
        end
    end

    assign sbox_in    = chain_r[N-1 -: W];
    assign din_req    = load_en_s;
    assign dout_valid = unload_en_s;
    assign dout       = unload_en_s & chain_r[N-1];

endmodule

// File: tb/tb_serial_state_reg.sv
// Self-checking bench for serial_state_reg: three parameterisations driven with
// directed and random operations, results compared against a lane-level model.
module tb_serial_state_reg;

    logic        clk;
    logic        rst_n;
    logic [2:0]  start_v;
    logic [2:0]  sub_en_v;
    logic [2:0]  abort_v;
    logic [2:0]  din_v;
    wire  [2:0]  din_req_v;
    wire  [2:0]  dout_v;
    wire  [2:0]  dval_v;
    wire  [2:0]  busy_v;
    wire  [2:0]  done_v;
    wire  [7:0]  sin_a;
    wire  [7:0]  sin_b;
    wire  [3:0]  sin_c;
    logic [7:0]  sout_a;
    logic [7:0]  sout_b;
    logic [3:0]  sout_c;
    int          mode_v [3];

    int total;
    int bad;

    int n_of [3] = '{16, 16, 4};
    int p_of [3] = '{1, 2, 3};
    int w_of [3] = '{8, 8, 4};
    int d_of [3] = '{2, 2, 1};

    serial_state_reg #(.W(8), .DEPTH(2), .PASSES(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub_en(sub_en_v[0]), .abort(abort_v[0]),
        .din(din_v[0]), .din_req(din_req_v[0]), .sbox_in(sin_a), .sbox_out(sout_a),
        .dout(dout_v[0]), .dout_valid(dval_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    serial_state_reg #(.W(8), .DEPTH(2), .PASSES(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub_en(sub_en_v[1]), .abort(abort_v[1]),
        .din(din_v[1]), .din_req(din_req_v[1]), .sbox_in(sin_b), .sbox_out(sout_b),
        .dout(dout_v[1]), .dout_valid(dval_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    serial_state_reg #(.W(4), .DEPTH(1), .PASSES(3)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub_en(sub_en_v[2]), .abort(abort_v[2]),
        .din(din_v[2]), .din_req(din_req_v[2]), .sbox_in(sin_c), .sbox_out(sout_c),
        .dout(dout_v[2]), .dout_valid(dval_v[2]), .busy(busy_v[2]), .done(done_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // S-box functions: 0 = bitwise invert, 1 = increment, other = rotate-left xor 0x5D.
    function automatic int sbox_f(input int mode, input int x, input int w);
        int m;
        m = (1 << w) - 1;
        case (mode)
            0:       return (~x) & m;
            1:       return (x + 1) & m;
            default: return (((x << 1) | (x >> (w - 1))) ^ 32'h5D) & m;
        endcase
    endfunction

    always_comb sout_a = 8'(sbox_f(mode_v[0], int'(sin_a), 8));
    always_comb sout_b = 8'(sbox_f(mode_v[1], int'(sin_b), 8));
    always_comb sout_c = 4'(sbox_f(mode_v[2], int'(sin_c), 4));

    function automatic int sbox_in_of(input int k);
        case (k)
            0:       return int'(sin_a);
            1:       return int'(sin_b);
            default: return int'(sin_c);
        endcase
    endfunction

    // Lane-level reference: split into lanes, substitute each lane once per pass.
    function automatic logic [31:0] model(input logic [31:0] data, input int depth, input int w,
                                          input int passes, input bit sub, input int mode);
        int          lanes [$];
        int          m;
        logic [31:0] r;
        m = (1 << w) - 1;
        for (int i = 0; i < depth; i++) lanes.push_back(int'((data >> ((depth - 1 - i) * w)) & m));
        if (sub) begin
            for (int p = 0; p < passes; p++)
                for (int i = 0; i < depth; i++) lanes[i] = sbox_f(mode, lanes[i], w);
        end
        r = 32'h0;
        for (int i = 0; i < depth; i++) r = (r << w) | 32'(lanes[i]);
        return r;
    endfunction

    // Drives one operation on instance k and records what the DUT did.
    task automatic run_op(input int k, input logic [31:0] data, input bit sub, input int mode,
                          input int g1, input int g2, input int abort_at, input int rst_at,
                          output logic [31:0] got, output int done_cnt, output int done_cyc,
                          output int req_cnt, output int val_cnt, output logic post_busy,
                          output logic post_valid, output logic post_done, output int post_sbox);
        int n;
        int tot;
        n = n_of[k];
        tot = (2 + p_of[k]) * n;
        got = 32'h0; done_cnt = 0; done_cyc = 0; req_cnt = 0; val_cnt = 0;
        post_busy = 1'b1; post_valid = 1'b1; post_done = 1'b1; post_sbox = -1;
        @(negedge clk);
        start_v[k] = 1'b1; sub_en_v[k] = sub; mode_v[k] = mode;
        for (int c = 1; c <= tot; c++) begin
            @(negedge clk);
            start_v[k]  = (c == g1 || c == g2);
            sub_en_v[k] = 1'($urandom);
            if (din_req_v[k]) req_cnt++;
            if (dval_v[k]) begin
                val_cnt++;
                got = {got[30:0], dout_v[k]};
            end
            if (done_v[k]) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            din_v[k] = (c <= n) ? data[n - c] : 1'($urandom);
            if (c == abort_at) begin
                abort_v[k] = 1'b1;
                @(negedge clk);
                abort_v[k] = 1'b0; start_v[k] = 1'b0;
                post_busy = busy_v[k]; post_valid = dval_v[k]; post_done = done_v[k];
                post_sbox = sbox_in_of(k);
                return;
            end
            if (c == rst_at) begin
                rst_n = 1'b0;
                #1;
                post_busy = busy_v[k]; post_valid = dval_v[k]; post_done = done_v[k];
                post_sbox = sbox_in_of(k);
                @(negedge clk);
                if (done_v[k]) done_cnt++;
                rst_n = 1'b1; start_v[k] = 1'b0;
                return;
            end
        end
        @(negedge clk);
        post_busy = busy_v[k]; post_valid = dval_v[k]; post_done = done_v[k];
        post_sbox = sbox_in_of(k);
        start_v[k] = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({din_req_v, dval_v, busy_v, done_v, dout_v} !== 15'h0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0", {din_req_v, dval_v, busy_v, done_v, dout_v});
        end
        total++;
        if ({sin_a, sin_b, sin_c} !== 20'h0) begin
            bad++; $display("FAIL reset_sbox_in got=%h exp=0", {sin_a, sin_b, sin_c});
        end
    endtask

    task automatic test_invert(input bit sub, input logic [31:0] exp);
        logic [31:0] got; int dc, dcyc, rc, vc, ps; logic pb, pv, pd;
        run_op(0, 32'hA53C, sub, 0, 0, 0, 0, 0, got, dc, dcyc, rc, vc, pb, pv, pd, ps);
        total++; if (got !== exp) begin bad++; $display("FAIL invert_data sub=%0d got=%h exp=%h", sub, got, exp); end
        total++; if (dcyc !== 48 || dc !== 1) begin bad++; $display("FAIL invert_done cyc=%0d cnt=%0d exp cyc=48 cnt=1", dcyc, dc); end
        total++; if (rc !== 16 || vc !== 16) begin bad++; $display("FAIL invert_strobes req=%0d valid=%0d exp 16/16", rc, vc); end
        total++; if (pb !== 1'b0 || pv !== 1'b0) begin bad++; $display("FAIL invert_idle busy=%b valid=%b exp 0/0", pb, pv); end
    endtask

    task automatic test_passes2();
        logic [31:0] got; int dc, dcyc, rc, vc, ps; logic pb, pv, pd;
        run_op(1, 32'h00FF, 1'b1, 1, 0, 0, 0, 0, got, dc, dcyc, rc, vc, pb, pv, pd, ps);
        total++; if (got !== 32'h0201) begin bad++; $display("FAIL passes2_data got=%h exp=0201", got); end
        total++; if (dcyc !== 64 || dc !== 1) begin bad++; $display("FAIL passes2_done cyc=%0d cnt=%0d exp 64/1", dcyc, dc); end
    endtask

    task automatic test_start_ignored();
        logic [31:0] got; int dc, dcyc, rc, vc, ps; logic pb, pv, pd;
        run_op(0, 32'hA53C, 1'b1, 0, 3, 20, 0, 0, got, dc, dcyc, rc, vc, pb, pv, pd, ps);
        total++; if (got !== 32'h5AC3) begin bad++; $display("FAIL busy_start_data got=%h exp=5ac3", got); end
        total++; if (dc !== 1 || dcyc !== 48) begin bad++; $display("FAIL busy_start_done cnt=%0d cyc=%0d exp 1/48", dc, dcyc); end
        total++; if (pb !== 1'b0) begin bad++; $display("FAIL busy_start_queued busy=%b exp=0", pb); end
    endtask

    task automatic test_abort();
        logic [31:0] got, data, exp; int dc, dcyc, rc, vc, ps; logic pb, pv, pd;
        data = 32'($urandom) & 32'hFFFF;
        run_op(0, data, 1'b1, 2, 0, 0, 21, 0, got, dc, dcyc, rc, vc, pb, pv, pd, ps);
        total++; if (pb !== 1'b0 || pd !== 1'b0 || dc !== 0) begin
            bad++; $display("FAIL abort_state busy=%b done=%b dones=%0d exp 0/0/0", pb, pd, dc); end
        total++; if (ps !== 0) begin bad++; $display("FAIL abort_chain sbox_in=%h exp=0", ps); end
        @(negedge clk);
        start_v[0] = 1'b1; abort_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0; abort_v[0] = 1'b0;
        total++; if (busy_v[0] !== 1'b0) begin bad++; $display("FAIL abort_wins_start busy=%b exp=0", busy_v[0]); end
        data = 32'($urandom) & 32'hFFFF;
        exp = model(data, 2, 8, 1, 1'b1, 2);
        run_op(0, data, 1'b1, 2, 0, 0, 0, 0, got, dc, dcyc, rc, vc, pb, pv, pd, ps);
        total++; if (got !== exp || dc !== 1) begin bad++; $display("FAIL abort_recover got=%h exp=%h dones=%0d", got, exp, dc); end
    endtask

    task automatic test_reset_unload();
        logic [31:0] got; int dc, dcyc, rc, vc, ps; logic pb, pv, pd;
        run_op(0, 32'hA53C, 1'b1, 0, 0, 0, 0, 40, got, dc, dcyc, rc, vc, pb, pv, pd, ps);
        total++; if (pv !== 1'b0 || pb !== 1'b0 || ps !== 0) begin
            bad++; $display("FAIL rst_unload valid=%b busy=%b sbox_in=%h exp 0/0/0", pv, pb, ps); end
        total++; if (dc !== 0 || pd !== 1'b0) begin bad++; $display("FAIL rst_unload_done dones=%0d exp=0", dc); end
    endtask

    task automatic test_depth1();
        logic [31:0] got, data, exp; int dc, dcyc, rc, vc, ps; logic pb, pv, pd;
        data = 32'($urandom_range(0, 15));
        exp = (data + 32'd3) & 32'hF;
        run_op(2, data, 1'b1, 1, 0, 0, 0, 0, got, dc, dcyc, rc, vc, pb, pv, pd, ps);
        total++; if (got !== exp) begin bad++; $display("FAIL depth1_data in=%h got=%h exp=%h", data, got, exp); end
        total++; if (dcyc !== 20 || dc !== 1) begin bad++; $display("FAIL depth1_done cyc=%0d cnt=%0d exp 20/1", dcyc, dc); end
    endtask

    task automatic test_random();
        logic [31:0] got, data, exp; int dc, dcyc, rc, vc, ps, k, mode; logic pb, pv, pd; bit sub;
        for (int it = 0; it < 12; it++) begin
            k = $urandom_range(0, 2);
            mode = $urandom_range(0, 2);
            sub = 1'($urandom);
            data = 32'($urandom) & ((32'h1 << n_of[k]) - 32'h1);
            exp = model(data, d_of[k], w_of[k], p_of[k], sub, mode);
            run_op(k, data, sub, mode, 0, 0, 0, 0, got, dc, dcyc, rc, vc, pb, pv, pd, ps);
            total++; if (got !== exp) begin
                bad++; $display("FAIL random_data dut=%0d in=%h sub=%0d mode=%0d got=%h exp=%h", k, data, sub, mode, got, exp); end
            total++; if (dcyc !== (2 + p_of[k]) * n_of[k] || dc !== 1) begin
                bad++; $display("FAIL random_done dut=%0d cyc=%0d cnt=%0d exp %0d/1", k, dcyc, dc, (2 + p_of[k]) * n_of[k]); end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0;
        start_v = 3'b0; sub_en_v = 3'b0; abort_v = 3'b0; din_v = 3'b0;
        mode_v = '{0, 0, 0};
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_invert(1'b1, 32'h5AC3);
        test_invert(1'b0, 32'hA53C);
        test_passes2();
        test_start_ignored();
        test_abort();
        test_reset_unload();
        test_depth1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
